// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//   Two requesters share one immediate-extension datapath: A is the
//   branch/jump-target path and B is the ALU-operand path. The winning 16-bit
//   immediate is extended to 32 bits and captured in a single-entry output
//   register. That register has a valid/ready handshake toward the downstream
//   stage.
//
//   Optional build macro:
//     IMM_EXT_FIXED_PRIO_EN - A always wins a tie and the round-robin pointer
//                             is removed. When the macro is undefined, ties
//                             alternate between A and B.
//
//   Ports:
//     Clk, Reset       clock (rising edge) and asynchronous active-high reset
//     ReqA/ImmA/ModeA  requester A: request, 16-bit immediate, extension mode
//     GntA             A accepted this cycle (combinational)
//     ReqB/ImmB/ModeB  requester B: request, 16-bit immediate, extension mode
//     GntB             B accepted this cycle (combinational)
//     OutValid         OutData/OutSrc hold a result
//     OutData          32-bit extended immediate
//     OutSrc           0 = result from A, 1 = result from B
//     OutReady         downstream consumes the result this cycle
//
//   Extension modes: 00 sign, 01 zero, 10 upper (imm << 16), 11 behaves as 00.
module imm_ext_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic [15:0] ImmA,
  input  logic [1:0]  ModeA,
  output logic        GntA,
  input  logic        ReqB,
  input  logic [15:0] ImmB,
  input  logic [1:0]  ModeB,
  output logic        GntB,
  output logic        OutValid,
  output logic [31:0] OutData,
  output logic        OutSrc,
  input  logic        OutReady
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               gnt_a;
  logic               gnt_b;
  logic               load;
  logic signed [15:0] sel_imm;
  logic [1:0]         sel_mode;
  logic signed [31:0] ext_d;
  logic signed [31:0] data_p0;
  logic               src_p0;

  function automatic logic signed [31:0] ext_imm(input logic signed [15:0] imm,
                                                 input logic [1:0]         mode);
    logic signed [31:0] r;
    case (mode)
      2'b01:   r = {16'h0000, imm};
      2'b10:   r = {imm, 16'h0000};
      default: r = imm;  // signed-to-signed assignment sign-extends
    endcase
    return r;
  endfunction

  // A new result can enter when the register is empty or being drained.
  assign accept = (state_q == EMPTY) || OutReady;

`ifdef IMM_EXT_FIXED_PRIO_EN
  assign gnt_a = accept & ReqA;
  assign gnt_b = accept & ReqB & ~ReqA;
`else
  // prio_q names the requester that wins the next tie (0 = A, 1 = B).
  logic prio_q;

  assign gnt_a = accept & ReqA & (~ReqB | ~prio_q);
  assign gnt_b = accept & ReqB & (~ReqA |  prio_q);

  // The pointer moves to the requester that did not get this grant.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prio_q <= 1'b0;
    end else if (gnt_a | gnt_b) begin
      prio_q <= gnt_a;
    end
  end
`endif

  assign load = gnt_a | gnt_b;

  // Arbitration and extension (combinational, ahead of the output register)
  always_comb begin
    sel_imm  = gnt_b ? ImmB  : ImmA;
    sel_mode = gnt_b ? ModeB : ModeA;
    ext_d    = ext_imm(sel_imm, sel_mode);
  end

  // Output register stage (_p0)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (load) state_d = FULL;
               else if (OutReady) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Reset clears the data as well, so a discarded result never reappears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_p0 <= '0;
      src_p0  <= 1'b0;
    end else if (load) begin
      data_p0 <= ext_d;
      src_p0  <= gnt_b;
    end
  end

  always_comb begin
    OutValid = (state_q == FULL);
    OutData  = $unsigned(data_p0);
    OutSrc   = src_p0;
    // Grants are masked while Reset is high. Masking here avoids relying on
    // the asynchronous clear of the state register.
    GntA     = gnt_a & ~Reset;
    GntB     = gnt_b & ~Reset;
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqA, ReqB, OutReady;
  logic [15:0] ImmA, ImmB;
  logic [1:0]  ModeA, ModeB;
  logic        GntA, GntB, OutValid, OutSrc;
  logic [31:0] OutData;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic        m_valid, m_src, m_prio;
  logic [31:0] m_data;
  logic        last_ga, last_gb;

  imm_ext_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .ImmA(ImmA), .ModeA(ModeA), .GntA(GntA),
    .ReqB(ReqB), .ImmB(ImmB), .ModeB(ModeB), .GntB(GntB),
    .OutValid(OutValid), .OutData(OutData), .OutSrc(OutSrc),
    .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{16{imm[15]}}, imm};
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_prio = 1'b0;
    last_ga = 1'b0; last_gb = 1'b0;
  endtask

  // This task runs one clock cycle. It checks the outputs and grants at the
  // falling edge and then advances the model at the rising edge. It returns
  // 1 time unit after the rising edge, so the caller can change the inputs
  // without racing the edge.
  task automatic cycle();
    logic acc, ga, gb, tie_b;
    @(negedge Clk);
    acc = !m_valid || OutReady;
`ifdef IMM_EXT_FIXED_PRIO_EN
    tie_b = 1'b0;
`else
    tie_b = m_prio;
`endif
    ga = 1'b0; gb = 1'b0;
    if (acc) begin
      if (ReqA && ReqB) begin
        ga = !tie_b; gb = tie_b;
      end else begin
        ga = ReqA; gb = ReqB;
      end
    end
    chk("gnt_a",     {31'b0, GntA},     {31'b0, ga});
    chk("gnt_b",     {31'b0, GntB},     {31'b0, gb});
    chk("out_valid", {31'b0, OutValid}, {31'b0, m_valid});
    chk("out_data",  OutData,           m_data);
    chk("out_src",   {31'b0, OutSrc},   {31'b0, m_src});
    @(posedge Clk);
    if (ga || gb) begin
      m_valid = 1'b1;
      m_data  = gb ? ref_ext(ImmB, ModeB) : ref_ext(ImmA, ModeA);
      m_src   = gb;
      m_prio  = ga;  // the loser of this grant wins the next tie
    end else if (OutReady) begin
      m_valid = 1'b0;
    end
    last_ga = ga; last_gb = gb;
    #1;
  endtask

  logic [31:0] mode_exp [4];
  logic        pend_a, pend_b;

  initial begin
    mode_exp[0] = 32'hFFFF_8001; mode_exp[1] = 32'h0000_8001;
    mode_exp[2] = 32'h8001_0000; mode_exp[3] = 32'hFFFF_8001;

    // Reset state: a request is present, but no grant may appear during reset.
    Reset = 1'b1; ReqA = 1'b1; ReqB = 1'b1; ImmA = '0; ImmB = '0;
    ModeA = '0; ModeB = '0; OutReady = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {31'b0, OutValid}, 32'd0);
    chk("rst_data",  OutData,           32'd0);
    chk("rst_src",   {31'b0, OutSrc},   32'd0);
    chk("rst_gnt",   {30'b0, GntA, GntB}, 32'd0);
    Reset = 1'b0;

    // Round robin with both requesters held high
    for (int i = 0; i < 4; i++) begin
      ImmA = 16'(i); ImmB = 16'(16'h100 + i);
      cycle();
`ifdef IMM_EXT_FIXED_PRIO_EN
      chk("rr_src", {31'b0, OutSrc}, 32'd0);
`else
      chk("rr_src", {31'b0, OutSrc}, {31'b0, i[0]});
`endif
      chk("rr_valid", {31'b0, OutValid}, 32'd1);
    end

    // Extension modes
    ReqB = 1'b0; ImmA = 16'h8001;
    for (int m = 0; m < 4; m++) begin
      ModeA = 2'(m);
      cycle();
      chk("mode_data", OutData, mode_exp[m]);
      chk("mode_src",  {31'b0, OutSrc}, 32'd0);
    end

    // Backpressure: the register is FULL from the last mode vector.
    ReqA = 1'b0; ReqB = 1'b1; ImmB = 16'h7FFF; ModeB = 2'b00; OutReady = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_held", OutData, mode_exp[3]);
    end
    OutReady = 1'b1;
    cycle();
    chk("bp_gntb", {31'b0, last_gb}, 32'd1);
    chk("bp_data", OutData, 32'h0000_7FFF);

    // Drain to empty, then a new request from B
    ReqB = 1'b0;
    cycle();
    chk("drain_valid", {31'b0, OutValid}, 32'd0);
    ReqB = 1'b1; ImmB = 16'h1234; ModeB = 2'b01;
    cycle();
    chk("drain_gntb", {31'b0, last_gb}, 32'd1);

    // Reset mid-run while FULL and stalled, with A pending
    ReqB = 1'b0; ReqA = 1'b1; ImmA = 16'hABCD; ModeA = 2'b10; OutReady = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, OutValid}, 32'd0);
    chk("arst_data",  OutData,           32'd0);
    chk("arst_gnt",   {30'b0, GntA, GntB}, 32'd0);
    model_reset();
    @(posedge Clk);
    #1 Reset = 1'b0;
    cycle();
    chk("arst_gnta", {31'b0, last_ga}, 32'd1);

    // Randomized traffic. Each requester holds its request until granted.
    pend_a = 1'b1; pend_b = 1'b0; ReqB = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (last_ga) pend_a = 1'b0;
      if (last_gb) pend_b = 1'b0;
      if (!pend_a) begin
        pend_a = ($urandom_range(0, 3) != 0);
        ImmA = 16'($urandom); ModeA = 2'($urandom);
      end
      if (!pend_b) begin
        pend_b = ($urandom_range(0, 3) != 0);
        ImmB = 16'($urandom); ModeB = 2'($urandom);
      end
      ReqA = pend_a; ReqB = pend_b;
      OutReady = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares one immediate-extension datapath between two requesters: the branch/jump-target path (A) and the ALU-operand path (B). Each requester presents a 16-bit immediate and an extension mode. The block arbitrates between them and extends the winning immediate to 32 bits. The result is held in a single-entry output register with a valid/ready handshake toward the downstream stage.

## Interface
Parameters:
- none; widths are fixed (16-bit in, 32-bit out).

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high; one clock, no other clock domains
- ReqA  in  1  requester A has an immediate pending
- ImmA  in  16  requester A immediate
- ModeA  in  2  requester A extension mode
- GntA  out  1  A accepted this cycle (combinational)
- ReqB  in  1  requester B has an immediate pending
- ImmB  in  16  requester B immediate
- ModeB  in  2  requester B extension mode
- GntB  out  1  B accepted this cycle (combinational)
- OutValid  out  1  OutData/OutSrc hold a result
- OutData  out  32  extended immediate
- OutSrc  out  1  0 = result from A, 1 = result from B
- OutReady  in  1  downstream consumes the result this cycle

## Operation
- Modes:
  - 00 sign-extend: {{16{imm[15]}}, imm}
  - 01 zero-extend: {16'h0000, imm}
  - 10 upper: {imm, 16'h0000}
  - 11 reserved, treated as 00
- Output register states:
  - EMPTY: OutValid = 0.
  - FULL: OutValid = 1.
- Accept condition: Accept = !OutValid || OutReady. At most one grant per cycle.
- Grant rules when Accept = 1:
  - Only one of ReqA/ReqB high: that requester is granted.
  - Both high: the requester indicated by priority pointer Prio is granted (0 = A, 1 = B).
  - Neither high: no grant.
- Grant rule when Accept = 0: GntA = GntB = 0, even if requests are present.
- Pointer update on any grant: Prio <= ~granted_id. The loser of a tie always wins the next tie.
- Requester protocol: Req, Imm and Mode must be held stable until the matching Gnt is seen high. The requester drops or changes Req only after that cycle.
- State transitions:
  - EMPTY --grant--> FULL
  - FULL & OutReady & grant --> FULL, with the new data loaded (back-to-back)
  - FULL & OutReady & no grant --> EMPTY
  - FULL & !OutReady --> FULL, OutData/OutSrc held unchanged
- Downstream protocol: OutData and OutSrc are stable whenever OutValid = 1 && OutReady = 0.

## Timing
- Reset values: OutValid = 0, OutData = 32'h0000_0000, OutSrc = 0, Prio = 0 (A preferred).
- Grant outputs during reset: GntA/GntB are forced to 0 while Reset is high.
- Latency: a grant in cycle N produces OutValid = 1 with the new data after the rising edge ending cycle N. The result is visible in cycle N+1.
- Throughput: one result per cycle while OutReady stays high and requests are present.
- Reset mid-operation: asserting Reset clears the held result asynchronously. The in-flight result is discarded, not replayed. A requester that was not yet granted keeps Req high and is served after reset releases.
- Simultaneous consume and grant in the same cycle: the old result is consumed and the new one is loaded. OutValid stays 1 with no bubble.
- Extension logic is purely combinational ahead of the output register. There is no combinational path from ImmA/ImmB to OutData.

## Configuration
- Macro: IMM_EXT_FIXED_PRIO_EN.
- Defined: A always wins a tie. Prio is removed and has no update logic. B is served only when ReqA = 0.
- Undefined (default): round-robin tie-breaking as described under Operation.

## Test plan
- Reset behaviour: assert Reset mid-run with OutValid = 1 -> OutValid = 0, OutData = 0 and GntA = GntB = 0 immediately, before the next clock edge. After release, ReqA = 1 is granted on the first cycle.
- Modes: ReqA with ImmA = 16'h8001 under ModeA = 00, 01, 10, 11 -> OutData = 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'hFFFF_8001 respectively, each with OutSrc = 0.
- Round-robin: ReqA and ReqB held high, OutReady = 1 -> grants alternate A, B, A, B starting with A. OutSrc sequence is 0, 1, 0, 1 with OutValid continuously 1.
- Backpressure: result FULL, OutReady = 0 for 3 cycles with ReqB = 1 and ImmB = 16'h7FFF, ModeB = 00 -> GntB = 0 and OutData unchanged for those 3 cycles. When OutReady rises, GntB = 1 that same cycle and OutData = 32'h0000_7FFF in the next cycle.
- Drain to empty: FULL with OutReady = 1 and no requests -> OutValid = 0 in the next cycle. A later ReqB is granted in its first cycle.
- Fixed priority (IMM_EXT_FIXED_PRIO_EN defined): ReqA and ReqB held high for 4 cycles -> GntA = 1 for all 4 cycles. GntB is granted only after ReqA drops.
